// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, sequencer state type and the schedule/round helper functions.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_W     = 512;
    localparam int NUM_WORDS   = 16;
    localparam int ROUND_IDX_W = 6;

    typedef enum logic {
        IDLE,
        RUN
    } sched_state_e;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Message-schedule sigmas (lower-case) and compression-round sigmas (upper-case).
    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [WORD_W-1:0] big_sig0(input logic [WORD_W-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] big_sig1(input logic [WORD_W-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x,
                                             input logic [WORD_W-1:0] y,
                                             input logic [WORD_W-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x,
                                              input logic [WORD_W-1:0] y,
                                              input logic [WORD_W-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_sched_expand.sv
// Combinational schedule expansion: produces W[t+16] from the current 16-word window taps.
module sha256_sched_expand
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_r0,
    input  logic [WORD_W-1:0] i_r1,
    input  logic [WORD_W-1:0] i_r9,
    input  logic [WORD_W-1:0] i_r14,
    output logic [WORD_W-1:0] o_w_new
);

    assign o_w_new = sig1(i_r14) + i_r9 + sig0(i_r1) + i_r0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule sequencer: loads a 512-bit block and streams W[0..ROUNDS-1].
// Optional performance counters are enabled with the SHA256_SCHED_PERF_EN macro.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
`ifdef SHA256_SCHED_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_blk_valid,
    output logic                   o_blk_ready,
    input  logic [BLOCK_W-1:0]     i_block,
    output logic [WORD_W-1:0]      o_w,
    output logic [ROUND_IDX_W-1:0] o_t,
    output logic                   o_w_valid,
    input  logic                   i_w_ready,
    output logic                   o_first,
    output logic                   o_last,
`ifdef SHA256_SCHED_PERF_EN
    output logic [PERF_W-1:0]      o_blk_cnt,
    output logic [PERF_W-1:0]      o_stall_cnt,
`endif
    output logic                   o_busy
);

    sched_state_e           state_q, state_d;
    logic [WORD_W-1:0]      r_q [NUM_WORDS];
    logic [WORD_W-1:0]      r_d [NUM_WORDS];
    logic [ROUND_IDX_W-1:0] t_q, t_d;
    logic [WORD_W-1:0]      w_new;
    logic                   load;
    logic                   adv;
    logic                   last_t;

    assign last_t = (t_q == ROUND_IDX_W'(ROUNDS - 1));

    always_comb begin
        state_d     = state_q;
        o_blk_ready = 1'b0;
        o_w_valid   = 1'b0;
        o_busy      = 1'b0;
        load        = 1'b0;
        adv         = 1'b0;
        case (state_q)
            IDLE: begin
                o_blk_ready = 1'b1;
                if (i_blk_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                o_w_valid = 1'b1;
                o_busy    = 1'b1;
                if (i_w_ready) begin
                    adv = 1'b1;
                    if (last_t) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sha256_sched_expand u_expand (
        .i_r0    (r_q[0]),
        .i_r1    (r_q[1]),
        .i_r9    (r_q[9]),
        .i_r14   (r_q[14]),
        .o_w_new (w_new)
    );

    // Window: load from the block, shift toward r[0] on a word handshake, else hold.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_window
        if (gi == NUM_WORDS - 1) begin : g_tail
            assign r_d[gi] = load ? i_block[WORD_W*gi +: WORD_W] :
                             adv  ? w_new : r_q[gi];
        end else begin : g_body
            assign r_d[gi] = load ? i_block[WORD_W*gi +: WORD_W] :
                             adv  ? r_q[gi+1] : r_q[gi];
        end
    end

    assign t_d = load ? '0 : (adv ? t_q + 1'b1 : t_q);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                r_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            r_q     <= r_d;
        end
    end

    assign o_w     = r_q[0];
    assign o_t     = t_q;
    assign o_first = (state_q == RUN) && (t_q == '0);
    assign o_last  = (state_q == RUN) && last_t;

`ifdef SHA256_SCHED_PERF_EN
    logic [PERF_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    assign blk_cnt_d   = (adv && last_t) ? blk_cnt_q + 1'b1 : blk_cnt_q;
    assign stall_cnt_d = (o_w_valid && !i_w_ready) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            blk_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            blk_cnt_q   <= blk_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_blk_cnt   = blk_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched (ROUNDS=64 and ROUNDS=16 instances).
module tb_sha256_msg_sched;

    localparam int ROUNDS = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk;
    logic [31:0]  w;
    logic [5:0]   t;
    logic         w_valid;
    logic         w_ready;
    logic         first;
    logic         last;
    logic         busy;

    logic         v16;
    logic         br16;
    logic [511:0] b16;
    logic [31:0]  w16;
    logic [5:0]   t16;
    logic         wv16;
    logic         rdy16;
    logic         first16;
    logic         last16;
    logic         busy16;

`ifdef SHA256_SCHED_PERF_EN
    logic [31:0] blk_cnt, stall_cnt, blk_cnt16, stall_cnt16;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int stall_total = 0;
    int blk_total = 0;

    logic [31:0]  exp_w [64];
    logic [511:0] blk_a, blk_b, junk;

    always #5 clk = ~clk;

    sha256_msg_sched #(.ROUNDS(ROUNDS)) u_dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_blk_valid (blk_valid),
        .o_blk_ready (blk_ready),
        .i_block     (blk),
        .o_w         (w),
        .o_t         (t),
        .o_w_valid   (w_valid),
        .i_w_ready   (w_ready),
        .o_first     (first),
        .o_last      (last),
`ifdef SHA256_SCHED_PERF_EN
        .o_blk_cnt   (blk_cnt),
        .o_stall_cnt (stall_cnt),
`endif
        .o_busy      (busy)
    );

    sha256_msg_sched #(.ROUNDS(16)) u_dut16 (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_blk_valid (v16),
        .o_blk_ready (br16),
        .i_block     (b16),
        .o_w         (w16),
        .o_t         (t16),
        .o_w_valid   (wv16),
        .i_w_ready   (rdy16),
        .o_first     (first16),
        .o_last      (last16),
`ifdef SHA256_SCHED_PERF_EN
        .o_blk_cnt   (blk_cnt16),
        .o_stall_cnt (stall_cnt16),
`endif
        .o_busy      (busy16)
    );

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // Straightforward FIPS 180-4 recurrence over a full 64-entry array.
    task automatic model(input logic [511:0] b);
        for (int i = 0; i < 16; i++) exp_w[i] = b[32*i +: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ms1(exp_w[i-2]) + exp_w[i-7] + ms0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Called at a negedge; returns at a negedge. Stops early when word stop_at is presented.
    // pulse_idx >= 0 drives i_blk_valid (with junk data) only while that word is presented.
    task automatic stream(input string name, input int stop_at, input bit bp, input int pulse_idx);
        int          idx = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] pw = '0;
        logic [5:0]  pt = '0;
        while (idx < ROUNDS && idx != stop_at) begin
            if (cyc >= 2000) begin
                n_errors++;
                $display("FAIL %s_timeout observed=%0d expected<%0d", name, cyc, 2000);
                break;
            end
            if (stalled) begin
                chk({name, "_stall_w"}, w, pw);
                chk({name, "_stall_t"}, t, pt);
            end
            chk({name, "_w_valid"}, w_valid, 1);
            chk({name, "_w"}, w, exp_w[idx]);
            chk({name, "_t"}, t, idx);
            chk({name, "_first"}, first, idx == 0);
            chk({name, "_last"}, last, idx == ROUNDS - 1);
            chk({name, "_blk_ready"}, blk_ready, 0);
            chk({name, "_busy"}, busy, 1);
            if (pulse_idx >= 0) begin
                blk_valid = (idx == pulse_idx);
                blk       = junk;
            end
            w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = !w_ready;
            if (stalled) stall_total++;
            pw = w;
            pt = t;
            if (w_ready) idx++;
            if (idx == ROUNDS) blk_total++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic send(input string name, input logic [511:0] b);
        blk_valid = 1'b1;
        blk       = b;
        chk({name, "_accept_ready"}, blk_ready, 1);
        @(posedge clk);
        @(negedge clk);
        blk_valid = 1'b0;
        blk       = junk;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_idle_ready"}, blk_ready, 1);
        chk({name, "_idle_valid"}, w_valid, 0);
        chk({name, "_idle_busy"}, busy, 0);
`ifdef SHA256_SCHED_PERF_EN
        chk({name, "_blk_cnt"}, blk_cnt, blk_total);
        chk({name, "_stall_cnt"}, stall_cnt, stall_total);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        blk_valid = 1'b0;
        blk       = '0;
        w_ready   = 1'b1;
        v16       = 1'b0;
        b16       = '0;
        rdy16     = 1'b1;
        junk      = rand_block();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_blk_ready", blk_ready, 1);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_w", w, 0);
        chk("rst_t", t, 0);
        chk("rst_first", first, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
`ifdef SHA256_SCHED_PERF_EN
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
`endif

        // "abc" block: hand-computed schedule words
        blk_a = '0;
        blk_a[31:0]    = 32'h6162_6380;
        blk_a[511:480] = 32'h0000_0018;
        model(blk_a);
        chk("abc_W0", exp_w[0], 32'h6162_6380);
        chk("abc_W15", exp_w[15], 32'h0000_0018);
        chk("abc_W16", exp_w[16], 32'h6162_6380);
        chk("abc_W17", exp_w[17], 32'h000F_0000);
        send("abc", blk_a);
        stream("abc", -1, 1'b0, -1);
        check_idle("abc_end");

        // Same block under random backpressure
        send("bp", blk_a);
        stream("bp", -1, 1'b1, -1);
        w_ready = 1'b1;
        check_idle("bp_end");

        // i_blk_valid pulsed mid-block with different data must be ignored
        send("pulse", blk_a);
        stream("pulse", -1, 1'b0, 10);
        check_idle("pulse_end");

        // Back-to-back: valid held high, block B presented after A is accepted
        blk_a = rand_block();
        blk_b = rand_block();
        model(blk_a);
        blk_valid = 1'b1;
        blk       = blk_a;
        @(posedge clk);
        @(negedge clk);
        blk = blk_b;
        stream("b2b_a", -1, 1'b0, -1);
        chk("b2b_bubble_ready", blk_ready, 1);
        chk("b2b_bubble_valid", w_valid, 0);
        @(posedge clk);
        @(negedge clk);
        blk_valid = 1'b0;
        blk       = junk;
        model(blk_b);
        chk("b2b_b_w0", w, blk_b[31:0]);
        stream("b2b_b", -1, 1'b0, -1);
        check_idle("b2b_end");

        // Reset at t=20 aborts the block
        send("abort", blk_a);
        model(blk_a);
        stream("abort", 20, 1'b0, -1);
        chk("abort_at_t", t, 20);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_w_valid", w_valid, 0);
        chk("abort_blk_ready", blk_ready, 1);
        chk("abort_t", t, 0);
        rst = 1'b0;
        stall_total = 0;
        blk_total   = 0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_idle_valid", w_valid, 0);
        blk_b = rand_block();
        model(blk_b);
        send("restart", blk_b);
        stream("restart", -1, 1'b1, -1);
        w_ready = 1'b1;
        check_idle("restart_end");

        // ROUNDS=16 instance: words emitted verbatim
        b16 = rand_block();
        v16 = 1'b1;
        chk("r16_ready", br16, 1);
        @(posedge clk);
        @(negedge clk);
        v16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("r16_valid", wv16, 1);
            chk("r16_w", w16, b16[32*i +: 32]);
            chk("r16_t", t16, i);
            chk("r16_first", first16, i == 0);
            chk("r16_last", last16, i == 15);
            @(posedge clk);
            @(negedge clk);
        end
        chk("r16_end_ready", br16, 1);
        chk("r16_end_valid", wv16, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
